// File: rtl/imem_load_arbiter.sv
// Single-port instruction memory arbiter: CPU fetch reads in RUN mode, byte-serial
// program loading (little-endian word assembly, sequential writes from word 0) otherwise.
module imem_load_arbiter #(
  parameter int unsigned AW       = 5,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_start,
  input  logic          l_byte_valid,
  input  logic [7:0]    l_byte,
  input  logic          l_end,
  output logic          l_ready,
  output logic          l_done,
  output logic [AW:0]   l_words,
  output logic          cpu_hold,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   WORD_ONE = {{AW{1'b0}}, 1'b1};

  logic [1:0]    state_q,    state_d;
  logic [AW-1:0] ptr_q,      ptr_d;
  logic [1:0]    bcnt_q,     bcnt_d;
  logic [31:0]   shift_q,    shift_d;
  logic [AW:0]   words_q,    words_d;
  logic          end_pend_q, end_pend_d;
  logic          f_valid_q,  f_valid_d;
  logic [31:0]   f_rdata_q,  f_rdata_d;
  logic          f_err_q,    f_err_d;
  logic          fetch_err;

  assign fetch_err = (f_addr[1:0] != 2'b00) || (f_addr[31:AW+2] != '0);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    words_d    = words_q;
    end_pend_d = end_pend_q;
    f_valid_d  = 1'b0;
    f_rdata_d  = f_rdata_q;
    f_err_d    = f_err_q;
    f_gnt      = 1'b0;
    m_addr     = ptr_q;
    m_we       = 1'b0;
    m_wdata    = '0;
    l_ready    = 1'b0;
    l_done     = 1'b0;
    cpu_hold   = 1'b1;

    case (state_q)
      S_RUN: begin
        cpu_hold = 1'b0;
        m_addr   = f_addr[AW+1:2];
        f_gnt    = f_req & ~l_start;
        if (l_start) begin
          state_d    = S_COLLECT;
          ptr_d      = '0;
          bcnt_d     = '0;
          shift_d    = '0;
          words_d    = '0;
          end_pend_d = 1'b0;
        end else if (f_req) begin
          f_valid_d = 1'b1;
          f_err_d   = fetch_err;
          f_rdata_d = fetch_err ? NOP_WORD : m_rdata;
        end
      end

      S_COLLECT: begin
        l_ready = 1'b1;
        if (l_byte_valid) begin
          shift_d[{bcnt_q, 3'b000} +: 8] = l_byte;
          bcnt_d = bcnt_q + 2'd1;
        end
        // A same-cycle byte counts before l_end decides between WRITE and FINISH.
        if (l_byte_valid && (bcnt_q == 2'd3)) begin
          state_d    = S_WRITE;
          end_pend_d = l_end;
        end else if (l_end) begin
          if (l_byte_valid || (bcnt_q != 2'd0)) begin
            state_d    = S_WRITE;
            end_pend_d = 1'b1;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_WRITE: begin
        m_we    = 1'b1;
        m_wdata = shift_q;
        ptr_d   = ptr_q + PTR_ONE;
        words_d = words_q + WORD_ONE;
        bcnt_d  = '0;
        shift_d = '0;
        if ((ptr_q == '1) || end_pend_q || l_end) begin
          state_d    = S_FINISH;
          end_pend_d = 1'b0;
        end else begin
          state_d = S_COLLECT;
        end
      end

      default: begin
        l_done  = 1'b1;
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      ptr_q      <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      words_q    <= '0;
      end_pend_q <= 1'b0;
      f_valid_q  <= 1'b0;
      f_rdata_q  <= '0;
      f_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      words_q    <= words_d;
      end_pend_q <= end_pend_d;
      f_valid_q  <= f_valid_d;
      f_rdata_q  <= f_rdata_d;
      f_err_q    <= f_err_d;
    end
  end

  assign f_valid = f_valid_q;
  assign f_rdata = f_rdata_q;
  assign f_err   = f_err_q;
  assign l_words = words_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: table-driven fetches, scoreboarded fetch responses and
// memory writes, and hand-written load / overflow / reset sequences.
module tb_imem_load_arbiter;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_valid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_start;
  logic          l_byte_valid;
  logic [7:0]    l_byte;
  logic          l_end;
  logic          l_ready;
  logic          l_done;
  logic [AW:0]   l_words;
  logic          cpu_hold;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  imem_load_arbiter #(.AW(AW), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_start(l_start), .l_byte_valid(l_byte_valid), .l_byte(l_byte), .l_end(l_end),
    .l_ready(l_ready), .l_done(l_done), .l_words(l_words), .cpu_hold(cpu_hold),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int unsigned i);
    return (i == 3) ? 32'h20102023 : (32'hA5000000 | i);
  endfunction

  // Memory model: combinational read, write on the rising edge.
  logic [31:0] mem [32];
  logic        preload;
  assign m_rdata = mem[m_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= mem_init(i);
    end else if (m_we) begin
      mem[m_addr] <= m_wdata;
    end
  end

  int unsigned total;
  int unsigned passes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct { logic err; logic [31:0] data; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  resp_t fq[$];
  wr_t   wq[$];

  always @(negedge clk) begin
    if (rst_n && f_valid) begin
      total++;
      if (fq.size() == 0) begin
        $display("FAIL fetch_unexpected: f_valid with rdata %h, none expected", f_rdata);
      end else begin
        resp_t r;
        r = fq.pop_front();
        if (f_err === r.err && f_rdata === r.data) passes++;
        else $display("FAIL fetch_resp: got err %b data %h expected err %b data %h",
                      f_err, f_rdata, r.err, r.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_we) begin
      total++;
      if (wq.size() == 0) begin
        $display("FAIL write_unexpected: addr %0d data %h, none expected", m_addr, m_wdata);
      end else begin
        wr_t w;
        w = wq.pop_front();
        if (m_addr === w.addr && m_wdata === w.data) passes++;
        else $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                      m_addr, m_wdata, w.addr, w.data);
      end
    end
  end

  typedef struct { logic [31:0] addr; logic exp_err; logic [31:0] exp_data; } fvec_t;
  fvec_t fv [8];

  // Caller is at a negedge; returns at a negedge with the strobe dropped.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    l_byte_valid = 1'b1;
    l_byte = b;
    #1;
    while (!l_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (!l_ready) begin
      total++;
      $display("FAIL byte_timeout: l_ready %b expected 1", l_ready);
    end
    @(negedge clk);
    l_byte_valid = 1'b0;
  endtask

  task automatic start_load();
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    chk("hold_after_start", cpu_hold, 1'b1);
    chk("ready_after_start", l_ready, 1'b1);
    chk("words_after_start", l_words, 0);
  endtask

  task automatic finish_load(input int unsigned exp_words);
    int unsigned dones;
    dones = 0;
    l_end = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      l_end = 1'b0;
      if (l_done) begin
        dones++;
        chk("hold_during_done", cpu_hold, 1'b1);
      end
    end
    chk("done_pulses", dones, 1);
    chk("hold_released", cpu_hold, 1'b0);
    chk("l_words", l_words, exp_words);
  endtask

  initial begin
    total = 0; passes = 0;
    rst_n = 1'b0; preload = 1'b1;
    f_req = 1'b0; f_addr = '0;
    l_start = 1'b0; l_byte_valid = 1'b0; l_byte = '0; l_end = 1'b0;

    fv[0] = '{32'h0000000C, 1'b0, mem_init(3)};
    fv[1] = '{32'h0000000E, 1'b1, 32'h00000013};
    fv[2] = '{32'h00000080, 1'b1, 32'h00000013};
    fv[3] = '{32'h00000000, 1'b0, mem_init(0)};
    fv[4] = '{32'h0000007C, 1'b0, mem_init(31)};
    fv[5] = '{32'h00000004, 1'b0, mem_init(1)};
    fv[6] = '{32'h80000010, 1'b1, 32'h00000013};
    fv[7] = '{32'h00000001, 1'b1, 32'h00000013};

    repeat (3) @(negedge clk);
    preload = 1'b0;
    chk("rst_f_valid", f_valid, 1'b0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_cpu_hold", cpu_hold, 1'b0);
    chk("rst_l_ready", l_ready, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back fetches from the table.
    for (int i = 0; i < 8; i++) begin
      f_req = 1'b1;
      f_addr = fv[i].addr;
      #1;
      chk("fetch_gnt", f_gnt, 1'b1);
      fq.push_back('{fv[i].exp_err, fv[i].exp_data});
      @(negedge clk);
    end
    f_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("fetch_drain", fq.size(), 0);

    // l_start beats a same-cycle fetch; two full words then l_end during WRITE.
    f_req = 1'b1; f_addr = 32'h0000000C;
    l_start = 1'b1;
    #1;
    chk("conflict_gnt", f_gnt, 1'b0);
    @(negedge clk);
    l_start = 1'b0; f_req = 1'b0;
    chk("hold_after_start", cpu_hold, 1'b1);
    wq.push_back('{5'd0, 32'h800010b7});
    wq.push_back('{5'd1, 32'h01000137});
    send_byte(8'hB7); send_byte(8'h10); send_byte(8'h00); send_byte(8'h80);
    send_byte(8'h37); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    finish_load(2);
    chk("mem_word0", mem[0], 32'h800010b7);
    chk("mem_word1", mem[1], 32'h01000137);

    // Partial word padded with zeros.
    start_load();
    wq.push_back('{5'd0, 32'h00002183});
    send_byte(8'h83); send_byte(8'h21);
    finish_load(1);

    // Byte and l_end in the same cycle.
    start_load();
    wq.push_back('{5'd0, 32'h00CCBBAA});
    send_byte(8'hAA); send_byte(8'hBB);
    l_byte_valid = 1'b1; l_byte = 8'hCC;
    finish_load(1);
    l_byte_valid = 1'b0;

    // l_end with nothing collected: straight to FINISH, no write.
    start_load();
    finish_load(0);

    // Overflow: 128 bytes fill all 32 words, the 129th is dropped.
    start_load();
    for (int w = 0; w < 32; w++) begin
      logic [7:0] b0;
      b0 = 8'(4 * w);
      wq.push_back('{AW'(w), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}});
    end
    for (int k = 0; k < 128; k++) send_byte(8'(k));
    begin
      int unsigned dones;
      dones = 0;
      for (int i = 0; i < 3; i++) begin
        l_byte_valid = 1'b1; l_byte = 8'hFF;
        #1;
        chk("overflow_ready", l_ready, 1'b0);
        if (l_done) dones++;
        @(negedge clk);
      end
      l_byte_valid = 1'b0;
      chk("overflow_done_pulses", dones, 1);
    end
    chk("overflow_words", l_words, 32);
    chk("overflow_hold", cpu_hold, 1'b0);
    chk("overflow_mem31", mem[31], 32'h7F7E7D7C);

    // Leave an errored response registered so the reset check below is meaningful.
    f_req = 1'b1; f_addr = 32'h00000002;
    fq.push_back('{1'b1, 32'h00000013});
    @(negedge clk);
    f_req = 1'b0;
    @(negedge clk);

    // Reset after six bytes of a load.
    start_load();
    wq.push_back('{5'd0, 32'h44332211});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    chk("words_before_reset", l_words, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_f_rdata", f_rdata, 32'h0);
    chk("mid_rst_f_err", f_err, 1'b0);
    chk("mid_rst_l_words", l_words, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 1'b0);
    chk("mid_rst_l_ready", l_ready, 1'b0);
    chk("mid_rst_l_done", l_done, 1'b0);
    chk("mid_rst_m_we", m_we, 1'b0);
    chk("mid_rst_m_wdata", m_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_word1_mem", mem[1], 32'h07060504);
    f_req = 1'b1; f_addr = 32'h00000000;
    #1;
    chk("post_rst_gnt", f_gnt, 1'b1);
    fq.push_back('{1'b0, 32'h44332211});
    @(negedge clk);
    f_addr = 32'h00000004;
    fq.push_back('{1'b0, 32'h07060504});
    @(negedge clk);
    f_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_fetch_drain", fq.size(), 0);
    chk("final_write_drain", wq.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
